// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks register indices FIRST_REG..LAST_REG and streams {idx, data} with a running checksum
module rf_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    assign busy    = state == READ || state == HOLD;
    assign done    = state == DONE;
    assign rd_addr = busy ? ptr : '0;
    // ptr only advances on a non-last handshake, so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= FIRST;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr      <= FIRST;
                    checksum <= '0;
                    state    <= READ;
                end
                READ: begin
                    out_data  <= rd_data;
                    out_idx   <= ptr;
                    out_last  <= ptr == LAST;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    checksum  <= checksum + out_data;
                    if (out_last) state <= DONE;
                    else begin
                        ptr   <= ptr + 1'b1;
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
